// File: rtl/riscv_ldst_tag_check_pkg.sv
// Shared constants and types for the load/store DIFT tag-check unit.
package riscv_ldst_tag_check_pkg;

   // TCR bit indices that enable the individual load/store checks
   localparam int unsigned LOADSTORE_CHECK_S  = 0;
   localparam int unsigned LOADSTORE_CHECK_SA = 1;
   localparam int unsigned LOADSTORE_CHECK_D  = 2;

   // Bit positions inside the 3-bit cause vector {D, SA, S}
   localparam int unsigned TCHK_CAUSE_S  = 0;
   localparam int unsigned TCHK_CAUSE_SA = 1;
   localparam int unsigned TCHK_CAUSE_D  = 2;
   localparam int unsigned TCHK_CAUSE_W  = 3;

   localparam int unsigned TCHK_PC_W = 32;

   typedef struct packed {
      logic [TCHK_PC_W-1:0]    pc;
      logic [TCHK_CAUSE_W-1:0] cause;
      logic                    is_store;
   } tag_viol_entry_t;

   typedef enum logic {
      TCHK_IDLE = 1'b0,
      TCHK_TRAP = 1'b1
   } tchk_state_e;

endpackage

// File: rtl/riscv_tag_viol_fifo.sv
// Violation log FIFO; a push into a full FIFO only succeeds alongside a pop.
module riscv_tag_viol_fifo
   import riscv_ldst_tag_check_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  tag_viol_entry_t data_i,
   output tag_viol_entry_t data_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   tag_viol_entry_t r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = pop_i & ~w_empty;
   assign w_push  = push_i & (~w_full | w_pop);

   // Entry storage; no reset needed, the head is masked while empty
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign empty_o = w_empty;
   assign full_o  = w_full;

endmodule

// File: rtl/riscv_ldst_tag_check.sv
// DIFT tag check for committed loads/stores: trap FSM, violation log and counter.
module riscv_ldst_tag_check
   import riscv_ldst_tag_check_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = 1,
   parameter int unsigned LOG_DEPTH = 4,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_i,
   input  logic                    is_store_i,
   input  logic [TAG_WIDTH-1:0]    src_tag_i,
   input  logic [TAG_WIDTH-1:0]    addr_tag_i,
   input  logic [TAG_WIDTH-1:0]    dest_tag_i,
   input  logic [TCHK_PC_W-1:0]    pc_i,
   input  logic [31:0]             tcr_i,
   input  logic [TAG_WIDTH-1:0]    tag_mask_i,
   input  logic                    log_only_i,
   input  logic                    exc_ack_i,
   input  logic                    cnt_clr_i,
   input  logic                    log_pop_i,
   output logic                    stall_o,
   output logic                    exc_req_o,
   output logic [TCHK_CAUSE_W-1:0] exc_cause_o,
   output logic                    log_valid_o,
   output logic [TCHK_PC_W-1:0]    log_pc_o,
   output logic [TCHK_CAUSE_W-1:0] log_cause_o,
   output logic                    log_is_store_o,
   output logic                    log_full_o,
   output logic                    log_overflow_o,
   output logic [CNT_WIDTH-1:0]    viol_cnt_o
);

   tchk_state_e               r_state;
   logic                      r_exc_req;
   logic [TCHK_CAUSE_W-1:0]   r_exc_cause;
   logic [CNT_WIDTH-1:0]      r_cnt;
   logic                      r_ovf;

   logic                      w_stall;
   logic                      w_accept;
   logic [TCHK_CAUSE_W-1:0]   w_cause;
   logic                      w_viol;
   logic                      w_log_empty;
   logic                      w_log_full;
   logic                      w_drop;
   tag_viol_entry_t           w_push_entry;
   tag_viol_entry_t           w_head;
   logic                      w_unused_tcr;

   // Only the three check-enable bits of the TCR matter here
   assign w_unused_tcr = ^tcr_i;

   assign w_stall  = (r_state == TCHK_TRAP);
   assign w_accept = valid_i & ~w_stall;

   // Per-operand hit: check enabled and any masked tag bit set
   always_comb begin
      w_cause                = '0;
      w_cause[TCHK_CAUSE_S]  = tcr_i[LOADSTORE_CHECK_S]  & (|(src_tag_i  & tag_mask_i));
      w_cause[TCHK_CAUSE_SA] = tcr_i[LOADSTORE_CHECK_SA] & (|(addr_tag_i & tag_mask_i));
      w_cause[TCHK_CAUSE_D]  = tcr_i[LOADSTORE_CHECK_D]  & (|(dest_tag_i & tag_mask_i));
   end

   assign w_viol = w_accept & (|w_cause);
   // A violation is lost only when the log is full and nothing leaves it this cycle
   assign w_drop = w_viol & w_log_full & ~log_pop_i;

   assign w_push_entry = '{pc: pc_i, cause: w_cause, is_store: is_store_i};

   riscv_tag_viol_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (w_viol),
      .pop_i   (log_pop_i),
      .data_i  (w_push_entry),
      .data_o  (w_head),
      .empty_o (w_log_empty),
      .full_o  (w_log_full)
   );

   // Trap FSM: enter on a trapping violation, leave only on controller ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= TCHK_IDLE;
         r_exc_req   <= 1'b0;
         r_exc_cause <= '0;
      end else begin
         case (r_state)
            TCHK_IDLE: begin
               if (w_viol && !log_only_i) begin
                  r_state     <= TCHK_TRAP;
                  r_exc_req   <= 1'b1;
                  r_exc_cause <= w_cause;
               end
            end
            TCHK_TRAP: begin
               if (exc_ack_i) begin
                  r_state   <= TCHK_IDLE;
                  r_exc_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= TCHK_IDLE;
               r_exc_req <= 1'b0;
            end
         endcase
      end
   end

   // Saturating violation counter and sticky overflow; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (cnt_clr_i) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_viol && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
         if (w_drop)                  r_ovf <= 1'b1;
      end
   end

   assign stall_o        = w_stall;
   assign exc_req_o      = r_exc_req;
   assign exc_cause_o    = r_exc_cause;
   assign log_valid_o    = ~w_log_empty;
   assign log_full_o     = w_log_full;
   assign log_pc_o       = w_head.pc;
   assign log_cause_o    = w_head.cause;
   assign log_is_store_o = w_head.is_store;
   assign log_overflow_o = r_ovf;
   assign viol_cnt_o     = r_cnt;

endmodule

// File: tb/tb_riscv_ldst_tag_check.sv
// Self-checking bench: directed vector table, corner sequences, random vs. model.
module tb_riscv_ldst_tag_check;
   import riscv_ldst_tag_check_pkg::*;

   localparam int unsigned TW = 2;
   localparam int unsigned LD = 4;
   localparam int unsigned CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0, is_store = 1'b0;
   logic [TW-1:0] src_tag = '0, addr_tag = '0, dest_tag = '0, tag_mask = '0;
   logic [31:0]   pc = '0, tcr = '0;
   logic          log_only = 1'b0, exc_ack = 1'b0, cnt_clr = 1'b0, log_pop = 1'b0;
   logic          stall, exc_req, log_valid, log_is_store, log_full, log_overflow;
   logic [2:0]    exc_cause, log_cause;
   logic [31:0]   log_pc;
   logic [CW-1:0] viol_cnt;

   int n_checks = 0;
   int n_errors = 0;

   riscv_ldst_tag_check #(.TAG_WIDTH(TW), .LOG_DEPTH(LD), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid), .is_store_i(is_store),
      .src_tag_i(src_tag), .addr_tag_i(addr_tag), .dest_tag_i(dest_tag),
      .pc_i(pc), .tcr_i(tcr), .tag_mask_i(tag_mask), .log_only_i(log_only),
      .exc_ack_i(exc_ack), .cnt_clr_i(cnt_clr), .log_pop_i(log_pop),
      .stall_o(stall), .exc_req_o(exc_req), .exc_cause_o(exc_cause),
      .log_valid_o(log_valid), .log_pc_o(log_pc), .log_cause_o(log_cause),
      .log_is_store_o(log_is_store), .log_full_o(log_full),
      .log_overflow_o(log_overflow), .viol_cnt_o(viol_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] tcr_of(input logic [2:0] en);
      logic [31:0] t;
      t = '0;
      t[LOADSTORE_CHECK_S]  = en[0];
      t[LOADSTORE_CHECK_SA] = en[1];
      t[LOADSTORE_CHECK_D]  = en[2];
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic st, input logic [TW-1:0] s, input logic [TW-1:0] a,
                        input logic [TW-1:0] d, input logic [31:0] p, input logic [2:0] en,
                        input logic lo, input logic ak, input logic cl, input logic pp);
      valid = v; is_store = st; src_tag = s; addr_tag = a; dest_tag = d; pc = p;
      tcr = tcr_of(en); tag_mask = 2'b10; log_only = lo; exc_ack = ak; cnt_clr = cl; log_pop = pp;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, '0, '0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Directed vectors: inputs for one cycle and outputs expected right after that edge
   typedef struct {
      string       name;
      logic        v, st;
      logic [1:0]  s, a, d;
      logic [31:0] pc;
      logic [2:0]  en;
      logic        lo, ack, clr, pop;
      logic        e_trap;
      logic [2:0]  e_cause;
      logic        e_lv, e_full, e_ovf;
      logic [31:0] e_lpc;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic v, input logic [1:0] s, input logic [31:0] p,
                               input logic lo, input logic ack, input logic clr, input logic pop,
                               input logic e_trap, input logic e_lv, input logic e_full,
                               input logic e_ovf, input logic [31:0] e_lpc, input logic [3:0] e_cnt);
      vec_t r;
      r.name = n; r.v = v; r.st = 1'b0; r.s = s; r.a = 2'b00; r.d = 2'b00; r.pc = p;
      r.en = 3'b001; r.lo = lo; r.ack = ack; r.clr = clr; r.pop = pop;
      r.e_trap = e_trap; r.e_cause = 3'b001; r.e_lv = e_lv; r.e_full = e_full;
      r.e_ovf = e_ovf; r.e_lpc = e_lpc; r.e_cnt = e_cnt;
      if (n == "idle") r.e_cause = 3'b000;
      if (n == "nohit") r.e_cause = 3'b000;
      return r;
   endfunction

   // Behavioural reference: log as a queue, counters as integers
   typedef struct {
      logic [31:0] pc;
      logic [2:0]  cause;
      logic        st;
   } ment_t;

   ment_t       mq[$];
   int          m_cnt;
   logic        m_ovf, m_trap;
   logic [2:0]  m_ecause;

   task automatic model_reset();
      mq.delete();
      m_cnt = 0; m_ovf = 1'b0; m_trap = 1'b0; m_ecause = 3'b000;
   endtask

   task automatic model_step();
      logic       acc, viol, popd, was_full;
      logic [2:0] c;
      ment_t      e;
      acc  = valid && !m_trap;
      c[0] = tcr[LOADSTORE_CHECK_S]  && ((src_tag  & tag_mask) != 0);
      c[1] = tcr[LOADSTORE_CHECK_SA] && ((addr_tag & tag_mask) != 0);
      c[2] = tcr[LOADSTORE_CHECK_D]  && ((dest_tag & tag_mask) != 0);
      viol = acc && (c != 3'b000);
      was_full = (mq.size() == LD);
      popd = log_pop && (mq.size() > 0);
      if (popd) void'(mq.pop_front());
      if (viol) begin
         if (!was_full || popd) begin
            e.pc = pc; e.cause = c; e.st = is_store;
            mq.push_back(e);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (cnt_clr) begin
         m_cnt = 0; m_ovf = 1'b0;
      end else if (viol && m_cnt < CNT_MAX) begin
         m_cnt++;
      end
      if (m_trap) begin
         if (exc_ack) m_trap = 1'b0;
      end else if (viol && !log_only) begin
         m_trap = 1'b1; m_ecause = c;
      end
   endtask

   task automatic model_check(input int cyc);
      string n;
      n = $sformatf("rand%0d", cyc);
      chk({n, ".exc_req"},   32'(exc_req),      32'(m_trap));
      chk({n, ".stall"},     32'(stall),        32'(m_trap));
      chk({n, ".exc_cause"}, 32'(exc_cause),    32'(m_ecause));
      chk({n, ".log_valid"}, 32'(log_valid),    32'(mq.size() > 0));
      chk({n, ".log_full"},  32'(log_full),     32'(mq.size() == LD));
      chk({n, ".overflow"},  32'(log_overflow), 32'(m_ovf));
      chk({n, ".cnt"},       32'(viol_cnt),     32'(m_cnt));
      if (mq.size() > 0) begin
         chk({n, ".log_pc"},    log_pc,             mq[0].pc);
         chk({n, ".log_cause"}, 32'(log_cause),     32'(mq[0].cause));
         chk({n, ".log_st"},    32'(log_is_store),  32'(mq[0].st));
      end else begin
         chk({n, ".log_pc0"},   log_pc,             32'h0);
      end
   endtask

   task automatic check_all_zero(input string n);
      chk({n, ".stall"},     32'(stall),        32'h0);
      chk({n, ".exc_req"},   32'(exc_req),      32'h0);
      chk({n, ".exc_cause"}, 32'(exc_cause),    32'h0);
      chk({n, ".log_valid"}, 32'(log_valid),    32'h0);
      chk({n, ".log_pc"},    log_pc,            32'h0);
      chk({n, ".log_cause"}, 32'(log_cause),    32'h0);
      chk({n, ".log_st"},    32'(log_is_store), 32'h0);
      chk({n, ".log_full"},  32'(log_full),     32'h0);
      chk({n, ".overflow"},  32'(log_overflow), 32'h0);
      chk({n, ".cnt"},       32'(viol_cnt),     32'h0);
   endtask

   initial begin
      // Directed table: detection, held trap, log-only fill/overflow, full push+pop
      tbl.push_back(mk("idle",   0, 2'b00, 32'h000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000, 0));
      tbl.push_back(mk("nohit",  1, 2'b01, 32'h040, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000, 0));
      tbl.push_back(mk("hitS",   1, 2'b10, 32'h044, 0, 0, 0, 0, 1, 1, 0, 0, 32'h044, 1));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk($sformatf("held%0d", i), 1, 2'b10, 32'h048, 0, 0, 0, 0, 1, 1, 0, 0, 32'h044, 1));
      tbl.push_back(mk("ack",    1, 2'b10, 32'h048, 0, 1, 0, 0, 0, 1, 0, 0, 32'h044, 1));
      tbl.push_back(mk("postack",1, 2'b10, 32'h050, 1, 0, 0, 0, 0, 1, 0, 0, 32'h044, 2));
      tbl.push_back(mk("pop0",   0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 1, 0, 0, 32'h050, 2));
      tbl.push_back(mk("pop1",   0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 0, 0, 0, 32'h000, 2));
      tbl.push_back(mk("popemp", 0, 2'b00, 32'h000, 0, 0, 1, 1, 0, 0, 0, 0, 32'h000, 0));
      tbl.push_back(mk("lo100",  1, 2'b10, 32'h100, 1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 1));
      tbl.push_back(mk("lo104",  1, 2'b10, 32'h104, 1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 2));
      tbl.push_back(mk("lo108",  1, 2'b10, 32'h108, 1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 3));
      tbl.push_back(mk("lo10c",  1, 2'b10, 32'h10C, 1, 0, 0, 0, 0, 1, 1, 0, 32'h100, 4));
      tbl.push_back(mk("lo110",  1, 2'b10, 32'h110, 1, 0, 0, 0, 0, 1, 1, 1, 32'h100, 5));
      tbl.push_back(mk("popA",   0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 1, 0, 1, 32'h104, 5));
      tbl.push_back(mk("popB",   0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 1, 0, 1, 32'h108, 5));
      tbl.push_back(mk("clrviol",1, 2'b10, 32'h200, 1, 0, 1, 0, 0, 1, 0, 0, 32'h108, 0));
      tbl.push_back(mk("fill",   1, 2'b10, 32'h204, 1, 0, 0, 0, 0, 1, 1, 0, 32'h108, 1));
      tbl.push_back(mk("fullpp", 1, 2'b10, 32'h208, 1, 0, 0, 1, 0, 1, 1, 0, 32'h10C, 2));
      tbl.push_back(mk("drainA", 0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 1, 0, 0, 32'h200, 2));
      tbl.push_back(mk("drainB", 0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 1, 0, 0, 32'h204, 2));
      tbl.push_back(mk("drainC", 0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 1, 0, 0, 32'h208, 2));
      tbl.push_back(mk("drainD", 0, 2'b00, 32'h000, 0, 0, 0, 1, 0, 0, 0, 0, 32'h000, 2));

      // Reset state
      idle_inputs();
      #12;
      check_all_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      foreach (tbl[i]) begin
         vec_t r;
         r = tbl[i];
         drive(r.v, r.st, r.s, r.a, r.d, r.pc, r.en, r.lo, r.ack, r.clr, r.pop);
         tick();
         chk({r.name, ".exc_req"},   32'(exc_req),      32'(r.e_trap));
         chk({r.name, ".stall"},     32'(stall),        32'(r.e_trap));
         chk({r.name, ".exc_cause"}, 32'(exc_cause),    32'(r.e_cause));
         chk({r.name, ".log_valid"}, 32'(log_valid),    32'(r.e_lv));
         chk({r.name, ".log_full"},  32'(log_full),     32'(r.e_full));
         chk({r.name, ".overflow"},  32'(log_overflow), 32'(r.e_ovf));
         chk({r.name, ".log_pc"},    log_pc,            r.e_lpc);
         chk({r.name, ".cnt"},       32'(viol_cnt),     32'(r.e_cnt));
      end

      // Counter saturation: 17 log-only violations, popping so the log never fills
      drive(0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 3'b001, 0, 0, 1, 0);
      tick();
      chk("sat.clr", 32'(viol_cnt), 32'h0);
      for (int i = 0; i < 17; i++) begin
         drive(1, 0, 2'b10, 2'b00, 2'b00, 32'h400 + 32'(i * 4), 3'b001, 1, 0, 0, 1);
         tick();
         if (i == 14) chk("sat.at15", 32'(viol_cnt), 32'd15);
      end
      chk("sat.cnt17",  32'(viol_cnt),     32'd15);
      chk("sat.ovf",    32'(log_overflow), 32'h0);
      chk("sat.exc",    32'(exc_req),      32'h0);
      chk("sat.head",   log_pc,            32'h440);
      // Fill the log (3 more), then one drop sets overflow
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 2'b10, 2'b00, 2'b00, 32'h500 + 32'(i * 4), 3'b001, 1, 0, 0, 0);
         tick();
      end
      chk("drop.full", 32'(log_full),     32'h1);
      chk("drop.ovf",  32'(log_overflow), 32'h1);
      chk("drop.head", log_pc,            32'h440);
      // Clear together with another dropped violation: clear wins
      drive(1, 0, 2'b10, 2'b00, 2'b00, 32'h600, 3'b001, 1, 0, 1, 0);
      tick();
      chk("clrwin.cnt", 32'(viol_cnt),     32'h0);
      chk("clrwin.ovf", 32'(log_overflow), 32'h0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 3'b001, 0, 0, 0, 1);
         tick();
      end
      chk("drain.lv", 32'(log_valid), 32'h0);

      // Store trap with address and destination hits; all checks enabled
      drive(1, 1, 2'b01, 2'b10, 2'b10, 32'h300, 3'b111, 0, 0, 0, 0);
      tick();
      chk("st.exc_req",   32'(exc_req),      32'h1);
      chk("st.stall",     32'(stall),        32'h1);
      chk("st.exc_cause", 32'(exc_cause),    32'h6);
      chk("st.log_cause", 32'(log_cause),    32'h6);
      chk("st.log_st",    32'(log_is_store), 32'h1);
      chk("st.log_pc",    log_pc,            32'h300);
      chk("st.cnt",       32'(viol_cnt),     32'h1);
      // log_only flipping while trapped must not release the trap
      drive(1, 0, 2'b10, 2'b10, 2'b10, 32'h304, 3'b111, 1, 0, 0, 0);
      tick();
      chk("st.lo_hold", 32'(exc_req),  32'h1);
      chk("st.lo_cnt",  32'(viol_cnt), 32'h1);
      // Asynchronous reset mid-trap, observed before any clock edge
      rst_n = 1'b0;
      #2;
      check_all_zero("rst_trap");
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Random stimulus against the reference model
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         valid    = ($urandom_range(0, 9) < 7);
         is_store = 1'($urandom_range(0, 1));
         src_tag  = TW'($urandom_range(0, 3));
         addr_tag = TW'($urandom_range(0, 3));
         dest_tag = TW'($urandom_range(0, 3));
         tag_mask = TW'($urandom_range(0, 3));
         pc       = $urandom() & 32'hFFFF_FFFC;
         tcr      = $urandom();
         log_only = 1'($urandom_range(0, 1));
         exc_ack  = ($urandom_range(0, 9) < 3);
         cnt_clr  = ($urandom_range(0, 39) == 0);
         log_pop  = ($urandom_range(0, 9) < 3);
         model_step();
         tick();
         model_check(cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time bound so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/riscv_ldst_tag_check.md
# riscv_ldst_tag_check

Parametrised DIFT tag-check unit for RI5CY loads and stores with multi-bit tags and a per-bit policy mask. It sits beside the LSU writeback path and evaluates the source, address and destination tags of each committed memory access against the Tag Check Register. It then either raises a held exception request to the controller or records the violation in a log FIFO without trapping. It also keeps a saturating violation counter for the debug/CSR side.

## Interface
- TAG_WIDTH, 1: bits per tag.
- LOG_DEPTH, 4: violation log entries; power of two, ≥2.
- CNT_WIDTH, 16: violation counter width.
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  check request: load writeback or store commit.
- is_store_i  in  1  1 = store, 0 = load.
- src_tag_i  in  TAG_WIDTH  load: memory data tag; store: rs2 tag.
- addr_tag_i  in  TAG_WIDTH  rs1 address tag.
- dest_tag_i  in  TAG_WIDTH  load: rd tag; store: destination memory tag.
- pc_i  in  32  PC of the access.
- tcr_i  in  32  Tag Check Register; bits LOADSTORE_CHECK_S/SA/D enable the checks.
- tag_mask_i  in  TAG_WIDTH  tag bits that are checked.
- log_only_i  in  1  1 = record only, never trap.
- exc_ack_i  in  1  controller has taken the exception.
- cnt_clr_i  in  1  clears the counter and the overflow flag.
- log_pop_i  in  1  pops the log head.
- stall_o  out  1  request not accepted this cycle.
- exc_req_o  out  1  held exception request.
- exc_cause_o  out  3  {D, SA, S} hits of the trapping access.
- log_valid_o  out  1  log not empty.
- log_pc_o  out  32  head entry PC.
- log_cause_o  out  3  head entry cause.
- log_is_store_o  out  1  head entry type.
- log_full_o  out  1  log full.
- log_overflow_o  out  1  sticky: a violation was dropped.
- viol_cnt_o  out  CNT_WIDTH  violation count.

## Operation
- Accept = valid_i & ~stall_o. Requests that are not accepted are ignored; the LSU holds them.
- Per operand: hit = enable bit & |(tag & tag_mask_i).
- cause = {dest_hit, addr_hit, src_hit}. Violation = accept & |cause.
- Counter on violation: increment, saturating at all-ones.
- Log on violation:
  - Not full: push {pc_i, cause, is_store_i}.
  - Full with no pop in the same cycle: drop the entry and set log_overflow_o.
  - Full with log_pop_i in the same cycle: push succeeds.
- Log pop: log_pop_i when the log is empty is ignored. The FIFO pointers wrap modulo LOG_DEPTH.
- cnt_clr_i clears the counter and log_overflow_o. It wins over a simultaneous increment or set.
- FSM:
  - IDLE → TRAP on violation with ~log_only_i. In that transition exc_cause_o is latched from cause.
  - TRAP holds exc_req_o=1 and stall_o=1.
  - TRAP → IDLE on exc_ack_i. exc_cause_o keeps its value until the next trap.
- Log-only violations never leave IDLE.
- A change of log_only_i while in TRAP has no effect; only exc_ack_i exits TRAP.
- exc_ack_i in IDLE is ignored.
- Reset mid-trap: return to IDLE. Log contents and the counter are lost.

## Timing
- Reset values:
  - stall_o, exc_req_o, log_valid_o, log_full_o, log_overflow_o: 0.
  - exc_cause_o, log_pc_o, log_cause_o, log_is_store_o, viol_cnt_o: 0.
- exc_req_o rises the cycle after the violating accept; it is registered.
- stall_o is a combinational decode of state == TRAP. It is still 1 in the exc_ack_i cycle and 0 in the following cycle.
- The next request can be accepted 1 cycle after ack.
- A log entry is visible on log_* the cycle after the push. The head advances the cycle after a pop.
- viol_cnt_o updates the cycle after the violation.
- Back-to-back log-only violations are accepted every cycle.

## Structure
- riscv_defines additions:
  - TCHK_CAUSE_S=0, TCHK_CAUSE_SA=1, TCHK_CAUSE_D=2.
  - Packed struct tag_viol_entry_t {pc, cause, is_store}.
  - enum tchk_state_e {TCHK_IDLE, TCHK_TRAP}.
- The existing LOADSTORE_CHECK_* bit indices are reused.
- One sub-module: riscv_tag_viol_fifo, a LOG_DEPTH × tag_viol_entry_t FIFO with push/pop/full/empty. The top level owns the FSM, hit logic, counter and overflow flag.

## Test plan
- TAG_WIDTH=2, tag_mask=2'b10, S enabled, src_tag=2'b01 → no violation, counter stays 0. With src_tag=2'b10 → exc_req_o=1 one cycle later, exc_cause_o=3'b001, stall_o=1.
- Trap held 5 cycles with valid_i high, then exc_ack_i → exc_req_o held all 5 cycles, no new accepts, no counter change. stall_o=0 one cycle after ack and the next accept proceeds.
- log_only_i=1, LOG_DEPTH=4, 5 consecutive violations with pc 0x100..0x110 → no exc_req_o, viol_cnt_o=5, log_full_o=1, log_overflow_o=1. Pops return 0x100, 0x104, 0x108, 0x10C.
- Full log with pop and violation in the same cycle → no overflow, entry count stays 4, new pc at the tail.
- CNT_WIDTH=4, 17 violations → viol_cnt_o=15. cnt_clr_i together with a violation → viol_cnt_o=0, log_overflow_o=0.
- All checks enabled, store with addr_tag and dest_tag set → cause=3'b110, log_is_store_o=1. Assert rst_n low during TRAP → every output 0 asynchronously.
